// File: rtl/lsq.sv
// In-order load/store queue: EX requests are queued, issued in order on dreq*, retired in order
// from drsp* into register write-back or a misalign/access-fault strobe.
module lsq #(
   parameter int C_XLEN         = 32,
   parameter int C_FIFO_DEPTH_X = 2,
   parameter int C_HPL          = 3
) (
   input  logic                  clk_i,
   input  logic                  clk_en_i,
   input  logic                  reset_i,
   input  logic                  ex_lq_wr_i,
   input  logic                  ex_sq_wr_i,
   input  logic [2:0]            ex_funct3_i,
   input  logic [4:0]            ex_regd_addr_i,
   input  logic [C_XLEN-1:0]     ex_regs2_data_i,
   input  logic [C_XLEN-1:0]     ex_addr_i,
   output logic                  ex_full_o,
   input  logic                  dreqready_i,
   output logic                  dreqvalid_o,
   output logic [1:0]            dreqhpl_o,
   output logic                  dreqwr_o,
   output logic [C_XLEN/8-1:0]   dreqbe_o,
   output logic [C_XLEN-1:0]     dreqaddr_o,
   output logic [C_XLEN-1:0]     dreqdata_o,
   output logic                  drspready_o,
   input  logic                  drspvalid_i,
   input  logic                  drsprerr_i,
   input  logic                  drspwerr_i,
   input  logic [C_XLEN-1:0]     drspdata_i,
   output logic                  ids_reg_wr_o,
   output logic [4:0]            ids_reg_addr_o,
   output logic [C_XLEN-1:0]     ids_reg_data_o,
   output logic                  hvec_err_o,
   output logic [1:0]            hvec_cause_o,
   output logic [C_XLEN-1:0]     hvec_addr_o
);
   localparam int NB    = C_XLEN / 8;
   localparam int DEPTH = 1 << C_FIFO_DEPTH_X;
   localparam int PW    = C_FIFO_DEPTH_X + 1;

   typedef struct packed {
      logic              st;
      logic [2:0]        f3;
      logic [4:0]        rd;
      logic [C_XLEN-1:0] addr;
      logic [C_XLEN-1:0] data;
   } ent_t;

   ent_t mem_q [DEPTH];

   // Pointers carry one extra wrap bit so that "all entries unissued" differs from "empty".
   logic [PW-1:0] wr_q, wr_d, is_q, is_d, rt_q, rt_d, count;

   logic              ids_wr_q;
   logic [4:0]        ids_addr_q;
   logic [C_XLEN-1:0] ids_data_q;
   logic              err_vld_q, err_vld_d;
   logic [1:0]        err_cause_q, err_cause_d;
   logic [C_XLEN-1:0] err_addr_q, err_addr_d;
   logic              hold_vld_q, hold_vld_d;
   logic [1:0]        hold_cause_q, hold_cause_d;
   logic [C_XLEN-1:0] hold_addr_q, hold_addr_d;

   logic              req, f3_ok, mis, enq, rej, iss, rsp;
   logic              rt_st, ret_err, wb_fire;
   logic [2:0]        rt_f3;
   logic [4:0]        rt_rd;
   logic [C_XLEN-1:0] rt_addr, ld_data;
   logic [1:0]        mis_cause;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;

   assign count     = wr_q - rt_q;
   assign ex_full_o = (count == PW'(DEPTH));

   // A store request overrides a simultaneous load request.
   assign req   = ex_lq_wr_i | ex_sq_wr_i;
   assign f3_ok = ex_sq_wr_i ? (!ex_funct3_i[2] && ex_funct3_i[1:0] != 2'b11)
                             : (ex_funct3_i[1:0] != 2'b11 && !(ex_funct3_i[2] && ex_funct3_i[1]));
   assign mis   = (ex_funct3_i[1:0] == 2'b01 && ex_addr_i[0]) ||
                  (ex_funct3_i[1:0] == 2'b10 && ex_addr_i[1:0] != 2'b00);
   assign enq   = clk_en_i && req && !ex_full_o && f3_ok && !mis;
   assign rej   = clk_en_i && req && !ex_full_o && !(f3_ok && !mis);
   assign mis_cause = {1'b0, ex_sq_wr_i};

   assign dreqvalid_o = (is_q != wr_q);
   assign drspready_o = (rt_q != is_q);
   assign iss         = clk_en_i && dreqvalid_o && dreqready_i;
   assign rsp         = clk_en_i && drspvalid_i && drspready_o;
   assign dreqhpl_o   = 2'(C_HPL);

   always_comb begin
      dreqwr_o   = 1'b0;
      dreqbe_o   = '0;
      dreqaddr_o = '0;
      dreqdata_o = '0;
      if (dreqvalid_o) begin
         dreqwr_o   = mem_q[is_q[C_FIFO_DEPTH_X-1:0]].st;
         dreqaddr_o = {mem_q[is_q[C_FIFO_DEPTH_X-1:0]].addr[C_XLEN-1:2], 2'b00};
         dreqbe_o   = '1;
         if (mem_q[is_q[C_FIFO_DEPTH_X-1:0]].st) begin
            case (mem_q[is_q[C_FIFO_DEPTH_X-1:0]].f3[1:0])
               2'b00: begin
                  dreqbe_o   = NB'(1) << mem_q[is_q[C_FIFO_DEPTH_X-1:0]].addr[1:0];
                  dreqdata_o = {(C_XLEN/8){mem_q[is_q[C_FIFO_DEPTH_X-1:0]].data[7:0]}};
               end
               2'b01: begin
                  dreqbe_o   = NB'(3) << mem_q[is_q[C_FIFO_DEPTH_X-1:0]].addr[1:0];
                  dreqdata_o = {(C_XLEN/16){mem_q[is_q[C_FIFO_DEPTH_X-1:0]].data[15:0]}};
               end
               default: dreqdata_o = mem_q[is_q[C_FIFO_DEPTH_X-1:0]].data;
            endcase
         end
      end
   end

   assign rt_st   = mem_q[rt_q[C_FIFO_DEPTH_X-1:0]].st;
   assign rt_f3   = mem_q[rt_q[C_FIFO_DEPTH_X-1:0]].f3;
   assign rt_rd   = mem_q[rt_q[C_FIFO_DEPTH_X-1:0]].rd;
   assign rt_addr = mem_q[rt_q[C_FIFO_DEPTH_X-1:0]].addr;
   assign ret_err = rsp && (rt_st ? drspwerr_i : drsprerr_i);
   assign wb_fire = rsp && !rt_st && !drsprerr_i && (rt_rd != 5'd0);
   assign ld_byte = drspdata_i[{rt_addr[1:0], 3'b000} +: 8];
   assign ld_half = rt_addr[1] ? drspdata_i[31:16] : drspdata_i[15:0];

   always_comb begin
      case (rt_f3)
         3'b000:  ld_data = {{(C_XLEN-8){ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {{(C_XLEN-8){1'b0}}, ld_byte};
         3'b001:  ld_data = {{(C_XLEN-16){ld_half[15]}}, ld_half};
         3'b101:  ld_data = {{(C_XLEN-16){1'b0}}, ld_half};
         default: ld_data = drspdata_i;
      endcase
   end

   always_comb begin
      wr_d = wr_q + PW'(enq);
      is_d = is_q + PW'(iss);
      rt_d = rt_q + PW'(rsp);
   end

   // Retire faults win the strobe; a colliding misalign waits one cycle in the hold register.
   always_comb begin
      err_vld_d    = 1'b0;
      err_cause_d  = err_cause_q;
      err_addr_d   = err_addr_q;
      hold_vld_d   = hold_vld_q;
      hold_cause_d = hold_cause_q;
      hold_addr_d  = hold_addr_q;
      if (ret_err) begin
         err_vld_d   = 1'b1;
         err_cause_d = {1'b1, rt_st};
         err_addr_d  = rt_addr;
         if (rej && !hold_vld_q) begin
            hold_vld_d   = 1'b1;
            hold_cause_d = mis_cause;
            hold_addr_d  = ex_addr_i;
         end
      end else if (hold_vld_q) begin
         err_vld_d   = 1'b1;
         err_cause_d = hold_cause_q;
         err_addr_d  = hold_addr_q;
         hold_vld_d  = rej;
         if (rej) begin
            hold_cause_d = mis_cause;
            hold_addr_d  = ex_addr_i;
         end
      end else if (rej) begin
         err_vld_d   = 1'b1;
         err_cause_d = mis_cause;
         err_addr_d  = ex_addr_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_q         <= '0;
         is_q         <= '0;
         rt_q         <= '0;
         ids_wr_q     <= 1'b0;
         ids_addr_q   <= '0;
         ids_data_q   <= '0;
         err_vld_q    <= 1'b0;
         err_cause_q  <= '0;
         err_addr_q   <= '0;
         hold_vld_q   <= 1'b0;
         hold_cause_q <= '0;
         hold_addr_q  <= '0;
      end else if (clk_en_i) begin
         wr_q         <= wr_d;
         is_q         <= is_d;
         rt_q         <= rt_d;
         ids_wr_q     <= wb_fire;
         if (wb_fire) begin
            ids_addr_q <= rt_rd;
            ids_data_q <= ld_data;
         end
         err_vld_q    <= err_vld_d;
         err_cause_q  <= err_cause_d;
         err_addr_q   <= err_addr_d;
         hold_vld_q   <= hold_vld_d;
         hold_cause_q <= hold_cause_d;
         hold_addr_q  <= hold_addr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem_q[wr_q[C_FIFO_DEPTH_X-1:0]].st   <= ex_sq_wr_i;
         mem_q[wr_q[C_FIFO_DEPTH_X-1:0]].f3   <= ex_funct3_i;
         mem_q[wr_q[C_FIFO_DEPTH_X-1:0]].rd   <= ex_regd_addr_i;
         mem_q[wr_q[C_FIFO_DEPTH_X-1:0]].addr <= ex_addr_i;
         mem_q[wr_q[C_FIFO_DEPTH_X-1:0]].data <= ex_regs2_data_i;
      end
   end

   assign ids_reg_wr_o   = ids_wr_q;
   assign ids_reg_addr_o = ids_addr_q;
   assign ids_reg_data_o = ids_data_q;
   assign hvec_err_o     = err_vld_q;
   assign hvec_cause_o   = err_cause_q;
   assign hvec_addr_o    = err_addr_q;
endmodule
